// File: rtl/m_lat_rf_pkg.sv
// Shared types for the latch register-file write sequencer: FSM state encoding and helpers.
// Optional read forwarding is enabled elsewhere by defining M_LAT_RF_FWD_EN.
package m_lat_rf_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_GATE  = 2'd2,
    ST_HOLD  = 2'd3
  } st_e;

  // A new write may be taken while idle or while the previous row is in its D-hold cycle.
  function automatic logic can_accept(input st_e st);
    return (st == ST_IDLE) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/m_lat_rf_gate_dec.sv
// Registered address -> one-hot row-gate decoder; out-of-range addresses never open a gate.
// Output comes straight from flops so the latch G pins see no decode glitches.
module m_lat_rf_gate_dec
  import m_lat_rf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] g
);

  logic             in_range_s;
  logic [DEPTH-1:0] g_nxt_s;
  logic [DEPTH-1:0] g_r;

  assign in_range_s = ({1'b0, addr} < (AW+1)'(DEPTH));

  // one-hot decode of the staged row, gated by enable and range
  always_comb begin
    g_nxt_s = '0;
    for (int r = 0; r < DEPTH; r++) begin
      g_nxt_s[r] = en & in_range_s & (addr == AW'(r));
    end
  end

  // gate register
  always_ff @(posedge clk) begin
    if (rst) begin
      g_r <= '0;
    end else begin
      g_r <= g_nxt_s;
    end
  end

  assign g = g_r;

endmodule

// File: rtl/m_lat_rf_ctrl.sv
// Write sequencer and registered read port for a DEPTH x DW latch-array register file.
// Define M_LAT_RF_FWD_EN to forward the in-flight write word to a matching read.
module m_lat_rf_ctrl
  import m_lat_rf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  output logic                busy,
  output logic [DEPTH-1:0]    lat_g,
  output logic [DW-1:0]       lat_d,
  input  logic [DEPTH*DW-1:0] lat_q,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data
);

  st_e           state_r;
  st_e           state_nxt_s;
  logic          wr_ready_r;
  logic          busy_r;
  logic          accept_s;
  logic          gate_en_s;
  logic [AW-1:0] stg_addr_r;
  logic [DW-1:0] lat_d_r;
  logic [DW-1:0] rd_row_s;
  logic [DW-1:0] rd_nxt_s;
  logic [DW-1:0] rd_data_r;
  logic          rd_in_range_s;
  logic          fwd_hit_s;

  assign accept_s = wr_valid & wr_ready_r;

  // next-state logic: SETUP, GATE and HOLD each last exactly one cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: state_nxt_s = ST_GATE;
      ST_GATE:  state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (accept_s) begin
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state plus handshake/status flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wr_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wr_ready_r <= can_accept(state_nxt_s);
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  // staging flops: D only moves on an accept edge, never while a gate is open
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_addr_r <= '0;
      lat_d_r    <= '0;
    end else if (accept_s) begin
      stg_addr_r <= wr_addr;
      lat_d_r    <= wr_data;
    end else begin
      stg_addr_r <= stg_addr_r;
      lat_d_r    <= lat_d_r;
    end
  end

  // The gate register is loaded when entering GATE, so G is high for that one cycle only.
  assign gate_en_s = (state_nxt_s == ST_GATE);

  m_lat_rf_gate_dec #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_gate_dec (
    .clk  (clk),
    .rst  (rst),
    .en   (gate_en_s),
    .addr (stg_addr_r),
    .g    (lat_g)
  );

  assign rd_in_range_s = ({1'b0, rd_addr} < (AW+1)'(DEPTH));

`ifdef M_LAT_RF_FWD_EN
  logic stg_in_range_s;
  assign stg_in_range_s = ({1'b0, stg_addr_r} < (AW+1)'(DEPTH));
  assign fwd_hit_s      = busy_r & stg_in_range_s & (rd_addr == stg_addr_r);
`else
  assign fwd_hit_s      = 1'b0;
`endif

  // read row select from the flattened latch outputs
  always_comb begin
    rd_row_s = '0;
    for (int r = 0; r < DEPTH; r++) begin
      rd_row_s = (rd_addr == AW'(r)) ? lat_q[r*DW +: DW] : rd_row_s;
    end
  end

  // read data source: out-of-range -> zero, forwarded word, or latch row
  always_comb begin
    rd_nxt_s = '0;
    if (!rd_in_range_s) begin
      rd_nxt_s = '0;
    end else if (fwd_hit_s) begin
      rd_nxt_s = lat_d_r;
    end else begin
      rd_nxt_s = rd_row_s;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else begin
      rd_data_r <= rd_nxt_s;
    end
  end

  assign wr_ready = wr_ready_r;
  assign busy     = busy_r;
  assign lat_d    = lat_d_r;
  assign rd_data  = rd_data_r;

endmodule
